mc_ctrl_fsm: RTL and testbench

//  Parametrised multi-cycle MIPS control FSM, successor to the fixed ctrl unit.
//  - Decodes inst and sequences datapath control words through a 5-bit state register.
//  - Drives ALU op, branch polarity and immediate sign-extension.
//  - Adds a bounded memory-wait timeout, a bus-error/illegal-instruction cause

---
 rtl/mc_ctrl_fsm.sv | 193 +++++++++++++++++++
 tb/tb_mc_ctrl_fsm.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle MIPS control FSM with memory-wait timeout and fault cause register.
// Define CTRL_EXC_EN for one-cycle exception entry; otherwise faults park in ERROR.
module mc_ctrl_fsm #(
    parameter int CTRL_W      = 16,
    parameter int TO_W        = 4,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [31:0]       inst,
    input  logic              mio_ready,
    output logic [4:0]        state_out,
    output logic [CTRL_W-1:0] ctrl_signals,
    output logic [3:0]        alu_op,
    output logic              beq,
    output logic              sign,
    output logic              mem_req,
    output logic              exc_pc_sel,
    output logic [1:0]        exc_cause
);

    typedef enum logic [4:0] {
        S_IF      = 5'd0,  S_ID    = 5'd1,  S_ADDR    = 5'd2,  S_MEM_R  = 5'd3,
        S_MEMREG  = 5'd4,  S_MEM_W = 5'd5,  S_RTYPE   = 5'd6,  S_ALUREG = 5'd7,
        S_BEQ     = 5'd8,  S_J     = 5'd9,  S_BNE     = 5'd10, S_JR     = 5'd11,
        S_LUI     = 5'd12, S_JAL   = 5'd13, S_ALUREGI = 5'd14, S_EXC    = 5'd29,
        S_ERROR   = 5'd30, S_START = 5'd31
    } state_t;

    localparam logic [3:0] ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_AND = 4'd2, ALU_OR  = 4'd3,
                           ALU_XOR = 4'd4, ALU_NOR = 4'd5, ALU_SLT = 4'd6, ALU_SLL = 4'd7,
                           ALU_SRL = 4'd8, ALU_SRA = 4'd9;

    localparam logic [5:0] OP_R    = 6'h00, OP_J    = 6'h02, OP_JAL  = 6'h03, OP_BEQ = 6'h04,
                           OP_BNE  = 6'h05, OP_ADDI = 6'h08, OP_SLTI = 6'h0A, OP_ANDI = 6'h0C,
                           OP_ORI  = 6'h0D, OP_XORI = 6'h0E, OP_LUI  = 6'h0F, OP_LW   = 6'h23,
                           OP_SW   = 6'h2B;

    state_t            state, state_nxt;
    logic [TO_W-1:0]   wait_cnt;
    logic [3:0]        alu_nxt;
    logic              beq_nxt, sign_nxt, fault, wait_st, timeout;
    logic [1:0]        cause_nxt, fault_cause;
    logic [15:0]       word;
    logic [5:0]        op, func;
    logic              unused_inst;

    assign op          = inst[31:26];
    assign func        = inst[5:0];
    assign unused_inst = ^inst[25:6];
    assign state_out   = state;
    assign wait_st     = (state == S_IF) || (state == S_MEM_R) || (state == S_MEM_W);
    assign timeout     = wait_st && !mio_ready && (wait_cnt == TO_W'(MEM_TIMEOUT));
    assign mem_req     = wait_st;

    always_comb begin
        state_nxt   = state;
        alu_nxt     = alu_op;
        beq_nxt     = beq;
        sign_nxt    = sign;
        cause_nxt   = exc_cause;
        fault       = 1'b0;
        fault_cause = 2'b00;
        case (state)
            S_IF, S_MEM_R, S_MEM_W: begin
                if (mio_ready) begin
                    case (state)
                        S_IF:    state_nxt = S_ID;
                        S_MEM_R: state_nxt = S_MEMREG;
                        default: state_nxt = S_IF;
                    endcase
                end else if (timeout) begin
                    fault       = 1'b1;
                    fault_cause = 2'b10;
                end
            end
            S_ID: begin
                case (op)
                    OP_R: begin
                        state_nxt = S_RTYPE;
                        case (func)
                            6'h20, 6'h08: alu_nxt = ALU_ADD;
                            6'h22: alu_nxt = ALU_SUB;
                            6'h24: alu_nxt = ALU_AND;
                            6'h25: alu_nxt = ALU_OR;
                            6'h26: alu_nxt = ALU_XOR;
                            6'h2A: alu_nxt = ALU_SLT;
                            6'h00: alu_nxt = ALU_SLL;
                            6'h02: alu_nxt = ALU_SRL;
                            6'h03: alu_nxt = ALU_SRA;
                            6'h27: alu_nxt = ALU_NOR;
                            default: begin
                                fault       = 1'b1;
                                fault_cause = 2'b01;
                            end
                        endcase
                    end
                    OP_J:   state_nxt = S_J;
                    OP_JAL: state_nxt = S_JAL;
                    OP_LUI: state_nxt = S_LUI;
                    OP_BEQ: begin state_nxt = S_BEQ; alu_nxt = ALU_SUB; beq_nxt = 1'b1; end
                    OP_BNE: begin state_nxt = S_BNE; alu_nxt = ALU_SUB; beq_nxt = 1'b0; end
                    OP_LW, OP_SW, OP_ADDI: begin state_nxt = S_ADDR; alu_nxt = ALU_ADD; end
                    OP_SLTI: begin state_nxt = S_ADDR; alu_nxt = ALU_SLT; end
                    OP_ANDI: begin state_nxt = S_ADDR; alu_nxt = ALU_AND; sign_nxt = 1'b0; end
                    OP_ORI:  begin state_nxt = S_ADDR; alu_nxt = ALU_OR;  sign_nxt = 1'b0; end
                    OP_XORI: begin state_nxt = S_ADDR; alu_nxt = ALU_XOR; sign_nxt = 1'b0; end
                    default: begin
                        fault       = 1'b1;
                        fault_cause = 2'b01;
                    end
                endcase
            end
            S_ADDR: begin
                case (op)
                    OP_LW:   state_nxt = S_MEM_R;
                    OP_SW:   state_nxt = S_MEM_W;
                    default: state_nxt = S_ALUREGI;
                endcase
            end
            S_RTYPE: state_nxt = (func == 6'h08) ? S_JR : S_ALUREG;
            S_ERROR: state_nxt = S_ERROR;
            default: state_nxt = S_IF;
        endcase
        if (fault) begin
`ifdef CTRL_EXC_EN
            state_nxt = S_EXC;
`else
            state_nxt = S_ERROR;
`endif
            cause_nxt = fault_cause;
            alu_nxt   = ALU_ADD;
            beq_nxt   = 1'b0;
        end
        if (state_nxt == S_IF) begin
            alu_nxt  = ALU_ADD;
            sign_nxt = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= S_START;
            alu_op    <= ALU_ADD;
            beq       <= 1'b0;
            sign      <= 1'b1;
            exc_cause <= 2'b00;
            wait_cnt  <= '0;
        end else begin
            state     <= state_nxt;
            alu_op    <= alu_nxt;
            beq       <= beq_nxt;
            sign      <= sign_nxt;
            exc_cause <= cause_nxt;
            // Counter restarts whenever the FSM moves, so each access gets a fresh budget.
            if (state_nxt != state)
                wait_cnt <= '0;
            else if (wait_st && !mio_ready)
                wait_cnt <= wait_cnt + TO_W'(1);
        end
    end

    always_comb begin
        case (state)
            S_IF:      word = 16'h5101;
            S_ID:      word = 16'h0003;
            S_ADDR:    word = 16'h0006;
            S_MEM_R:   word = 16'h3006;
            S_MEMREG:  word = 16'h0220;
            S_MEM_W:   word = 16'h2806;
            S_RTYPE:   word = 16'h0004;
            S_ALUREG:  word = 16'h0060;
            S_BEQ:     word = 16'h800C;
            S_J:       word = 16'h4010;
            S_BNE:     word = 16'h800C;
            S_JR:      word = 16'h4008;
            S_LUI:     word = 16'h0420;
            S_JAL:     word = 16'h46B0;
            S_ALUREGI: word = 16'h0020;
            S_EXC:     word = 16'h4000;
            default:   word = 16'h0000;
        endcase
        ctrl_signals        = '0;
        ctrl_signals[15:0]  = word;
    end

`ifdef CTRL_EXC_EN
    assign exc_pc_sel = (state == S_EXC);
`else
    assign exc_pc_sel = 1'b0;
`endif

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Directed table-driven bench for mc_ctrl_fsm; expectations follow CTRL_EXC_EN when defined.
module tb_mc_ctrl_fsm;

    localparam logic [3:0] ADD = 4'd0, SUB = 4'd1, AND_ = 4'd2, OR_ = 4'd3, NOR_ = 4'd5,
                           SLT = 4'd6, SLL = 4'd7;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [31:0] inst;
    logic        mio_ready;
    logic [4:0]  state_out;
    logic [15:0] ctrl_signals;
    logic [3:0]  alu_op;
    logic        beq, sign, mem_req, exc_pc_sel;
    logic [1:0]  exc_cause;

    int tests = 0;
    int fails = 0;

    mc_ctrl_fsm #(.CTRL_W(16), .TO_W(4), .MEM_TIMEOUT(15)) dut (
        .clk(clk), .reset_n(reset_n), .inst(inst), .mio_ready(mio_ready),
        .state_out(state_out), .ctrl_signals(ctrl_signals), .alu_op(alu_op),
        .beq(beq), .sign(sign), .mem_req(mem_req), .exc_pc_sel(exc_pc_sel),
        .exc_cause(exc_cause)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] inst;
        logic        rdy;
        logic [4:0]  st;
        logic [15:0] ctrl;
        logic [3:0]  alu;
        logic        bq;
        logic        sg;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [15:0] ctrl_of(input logic [4:0] st);
        case (st)
            5'd0:  return 16'h5101;  5'd1:  return 16'h0003;  5'd2:  return 16'h0006;
            5'd3:  return 16'h3006;  5'd4:  return 16'h0220;  5'd5:  return 16'h2806;
            5'd6:  return 16'h0004;  5'd7:  return 16'h0060;  5'd8:  return 16'h800C;
            5'd9:  return 16'h4010;  5'd10: return 16'h800C;  5'd11: return 16'h4008;
            5'd12: return 16'h0420;  5'd13: return 16'h46B0;  5'd14: return 16'h0020;
            5'd29: return 16'h4000;
            default: return 16'h0000;
        endcase
    endfunction

    task automatic add(input logic [31:0] i, input logic r, input logic [4:0] st,
                       input logic [3:0] alu, input logic bq, input logic sg);
        vec_t v;
        v.inst = i; v.rdy = r; v.st = st; v.ctrl = ctrl_of(st);
        v.alu = alu; v.bq = bq; v.sg = sg;
        vecs.push_back(v);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_st(input string nm, input logic [4:0] st, input logic [1:0] cause,
                          input logic pcsel);
        chk({nm, ".state"}, 32'(state_out), 32'(st));
        chk({nm, ".ctrl"}, 32'(ctrl_signals), 32'(ctrl_of(st)));
        chk({nm, ".mem_req"}, 32'(mem_req), 32'(st == 5'd0 || st == 5'd3 || st == 5'd5));
        chk({nm, ".cause"}, 32'(exc_cause), 32'(cause));
        chk({nm, ".pcsel"}, 32'(exc_pc_sel), 32'(pcsel));
    endtask

    task automatic reset_pulse(input string nm);
        reset_n = 1'b0;
        #1;
        chk_st({nm, ".rst"}, 5'd31, 2'b00, 1'b0);
        chk({nm, ".rst.alu"}, 32'(alu_op), 32'(ADD));
        chk({nm, ".rst.sign"}, 32'(sign), 32'd1);
        reset_n = 1'b1;
        step();
        chk_st({nm, ".if"}, 5'd0, 2'b00, 1'b0);
    endtask

    task automatic fault_tail(input string nm, input logic [1:0] cause);
`ifdef CTRL_EXC_EN
        chk_st({nm, ".exc"}, 5'd29, cause, 1'b1);
        chk({nm, ".alu"}, 32'(alu_op), 32'(ADD));
        chk({nm, ".beq"}, 32'(beq), 32'd0);
        step();
        chk_st({nm, ".back"}, 5'd0, cause, 1'b0);
`else
        chk_st({nm, ".err"}, 5'd30, cause, 1'b0);
        chk({nm, ".alu"}, 32'(alu_op), 32'(ADD));
        chk({nm, ".beq"}, 32'(beq), 32'd0);
        for (int k = 0; k < 20; k++) begin
            step();
            chk({nm, ".hold"}, 32'(state_out), 32'd30);
        end
        chk({nm, ".hcause"}, 32'(exc_cause), 32'(cause));
        reset_pulse(nm);
`endif
    endtask

    task automatic illegal(input string nm, input logic [31:0] bad);
        mio_ready = 1'b1;
        inst = 32'h10850003;
        step(); step();
        chk({nm, ".pre_beq"}, 32'(beq), 32'd1);
        step();
        inst = bad;
        step();
        chk({nm, ".id"}, 32'(state_out), 32'd1);
        step();
        fault_tail(nm, 2'b01);
    endtask

    initial begin
        reset_n   = 1'b0;
        inst      = '0;
        mio_ready = 1'b0;

        add(32'h00851020, 1, 0, ADD, 0, 1); add(32'h00851020, 1, 1, ADD, 0, 1);
        add(32'h00851020, 1, 6, ADD, 0, 1); add(32'h00851020, 1, 7, ADD, 0, 1);
        add(32'h00851020, 1, 0, ADD, 0, 1); add(32'h00851020, 0, 0, ADD, 0, 1);
        add(32'h3088FFFF, 1, 1, ADD, 0, 1); add(32'h3088FFFF, 1, 2, AND_, 0, 0);
        add(32'h3088FFFF, 1, 14, AND_, 0, 0); add(32'h3088FFFF, 1, 0, ADD, 0, 1);
        add(32'h10850003, 1, 1, ADD, 0, 1); add(32'h10850003, 1, 8, SUB, 1, 1);
        add(32'h10850003, 1, 0, ADD, 1, 1);
        add(32'h14850003, 1, 1, ADD, 1, 1); add(32'h14850003, 1, 10, SUB, 0, 1);
        add(32'h14850003, 1, 0, ADD, 0, 1);
        add(32'h00851022, 1, 1, ADD, 0, 1); add(32'h00851022, 1, 6, SUB, 0, 1);
        add(32'h00851022, 1, 7, SUB, 0, 1); add(32'h00851022, 1, 0, ADD, 0, 1);
        add(32'h00800008, 1, 1, ADD, 0, 1); add(32'h00800008, 1, 6, ADD, 0, 1);
        add(32'h00800008, 1, 11, ADD, 0, 1); add(32'h00800008, 1, 0, ADD, 0, 1);
        add(32'h00041080, 1, 1, ADD, 0, 1); add(32'h00041080, 1, 6, SLL, 0, 1);
        add(32'h00041080, 1, 7, SLL, 0, 1); add(32'h00041080, 1, 0, ADD, 0, 1);
        add(32'h3488000F, 1, 1, ADD, 0, 1); add(32'h3488000F, 1, 2, OR_, 0, 0);
        add(32'h3488000F, 1, 14, OR_, 0, 0); add(32'h3488000F, 1, 0, ADD, 0, 1);
        add(32'hAC880004, 1, 1, ADD, 0, 1); add(32'hAC880004, 1, 2, ADD, 0, 1);
        add(32'hAC880004, 1, 5, ADD, 0, 1); add(32'hAC880004, 1, 0, ADD, 0, 1);
        add(32'h0C000010, 1, 1, ADD, 0, 1); add(32'h0C000010, 1, 13, ADD, 0, 1);
        add(32'h0C000010, 1, 0, ADD, 0, 1);
        add(32'h3C081234, 1, 1, ADD, 0, 1); add(32'h3C081234, 1, 12, ADD, 0, 1);
        add(32'h3C081234, 1, 0, ADD, 0, 1);
        add(32'h2888000A, 1, 1, ADD, 0, 1); add(32'h2888000A, 1, 2, SLT, 0, 1);
        add(32'h2888000A, 1, 14, SLT, 0, 1); add(32'h2888000A, 1, 0, ADD, 0, 1);
        add(32'h08000010, 1, 1, ADD, 0, 1); add(32'h08000010, 1, 9, ADD, 0, 1);
        add(32'h08000010, 1, 0, ADD, 0, 1);
        add(32'h00851027, 1, 1, ADD, 0, 1); add(32'h00851027, 1, 6, NOR_, 0, 1);
        add(32'h00851027, 1, 7, NOR_, 0, 1); add(32'h00851027, 1, 0, ADD, 0, 1);

        #12;
        chk_st("reset", 5'd31, 2'b00, 1'b0);
        chk("reset.alu", 32'(alu_op), 32'(ADD));
        chk("reset.beq", 32'(beq), 32'd0);
        chk("reset.sign", 32'(sign), 32'd1);
        reset_n = 1'b1;

        foreach (vecs[i]) begin
            inst      = vecs[i].inst;
            mio_ready = vecs[i].rdy;
            step();
            chk($sformatf("v%0d.state", i), 32'(state_out), 32'(vecs[i].st));
            chk($sformatf("v%0d.ctrl", i), 32'(ctrl_signals), 32'(vecs[i].ctrl));
            chk($sformatf("v%0d.alu", i), 32'(alu_op), 32'(vecs[i].alu));
            chk($sformatf("v%0d.beq", i), 32'(beq), 32'(vecs[i].bq));
            chk($sformatf("v%0d.sign", i), 32'(sign), 32'(vecs[i].sg));
            chk($sformatf("v%0d.cause", i), 32'(exc_cause), 32'd0);
        end

        // lw with three wait cycles in MEM_R
        inst = 32'h8C880004; mio_ready = 1'b1;
        step(); chk_st("lw.id", 5'd1, 2'b00, 1'b0);
        step(); chk_st("lw.addr", 5'd2, 2'b00, 1'b0);
        mio_ready = 1'b0;
        step(); chk_st("lw.memr", 5'd3, 2'b00, 1'b0);
        for (int k = 0; k < 3; k++) begin
            step(); chk_st($sformatf("lw.wait%0d", k), 5'd3, 2'b00, 1'b0);
        end
        mio_ready = 1'b1;
        step(); chk_st("lw.memreg", 5'd4, 2'b00, 1'b0);
        step(); chk_st("lw.if", 5'd0, 2'b00, 1'b0);

        // ready arrives exactly in the timeout cycle: no fault
        inst = 32'h00851020; mio_ready = 1'b0;
        for (int k = 0; k < 15; k++) begin
            step(); chk($sformatf("rw.wait%0d", k), 32'(state_out), 32'd0);
        end
        mio_ready = 1'b1;
        step(); chk_st("rw.id", 5'd1, 2'b00, 1'b0);
        step(); step(); step();
        chk_st("rw.if", 5'd0, 2'b00, 1'b0);

        // reset asserted just before a MEM_R timeout would fire
        inst = 32'h8C880004;
        step(); step();
        mio_ready = 1'b0;
        step(); chk_st("rm.memr", 5'd3, 2'b00, 1'b0);
        for (int k = 0; k < 15; k++) step();
        chk("rm.held", 32'(state_out), 32'd3);
        reset_pulse("rm");

        illegal("ill_op", 32'hFC000000);
        illegal("ill_fn", 32'h00000001);

        // IF timeout after MEM_TIMEOUT wait cycles
        inst = 32'h00851020; mio_ready = 1'b0;
        for (int k = 0; k < 15; k++) begin
            step(); chk($sformatf("to.wait%0d", k), 32'(state_out), 32'd0);
        end
        step();
        fault_tail("to", 2'b10);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
